// File: rtl/scan_ctrl_pkg.sv
// scan_ctrl_pkg -- shared types and constants for the scan chain controller.
//   state_e        : controller FSM states
//   CHAIN_LEN_DEF  : default number of flops in the driven scan chain
package scan_ctrl_pkg;

  localparam int CHAIN_LEN_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/scan_shreg.sv
// scan_shreg -- PISO/SIPO shift register used for both pattern load and
// response unload. Parallel load has priority over shift; a shift moves
// every bit one place toward the MSB and takes sin into the LSB, so the
// MSB is the serial output.
//   clk, rst : clock, synchronous active-high reset (clears contents)
//   load/din : parallel load of din
//   shift    : shift toward MSB, sin enters at LSB
//   q        : current register contents (q[W-1] is the serial output)
module scan_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  logic [W-1:0] sh_d, sh_q;

  always_comb begin
    sh_d = sh_q;
    if (load)       sh_d = din;
    else if (shift) sh_d = {sh_q[W-2:0], sin};
  end

  always_ff @(posedge clk) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  assign q = sh_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl -- drives one load / capture / unload sequence into an
// external scan chain of CHAIN_LEN flops.
//   CK, RST  : clock, synchronous active-high reset
//   START    : request a sequence (taken in IDLE only)
//   PATTERN  : vector to load, bit k lands in chain flop k
//   SO       : chain tail serial output
//   SE, SI   : scan enable / serial data into chain flop 0
//   RESP     : captured response, bit k = value captured in flop k
//   BUSY     : high outside IDLE
//   DONE     : one-cycle pulse in FINISH; RESP valid from then on
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PATTERN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic [CHAIN_LEN-1:0] RESP,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int             CW   = $clog2(CHAIN_LEN) + 1;
  localparam logic [CW-1:0]  LAST = CW'(CHAIN_LEN - 1);

  state_e                 state_d, state_q;
  logic [CW-1:0]          cnt_d, cnt_q;
  logic [CHAIN_LEN-1:0]   resp_d, resp_q;
  logic                   se_d, se_q;
  logic                   busy_d, busy_q;
  logic                   done_d, done_q;

  logic                   sh_load, sh_shift, sh_sin;
  logic [CHAIN_LEN-1:0]   sh_q;

  // One register serves both directions: the pattern leaves from the MSB
  // during LOAD while zeros fill in, then SO samples fill in at the LSB
  // during UNLOAD so the first sample ends up in the MSB.
  scan_shreg #(.W(CHAIN_LEN)) u_shreg (
    .clk   (CK),
    .rst   (RST),
    .load  (sh_load),
    .din   (PATTERN),
    .shift (sh_shift),
    .sin   (sh_sin),
    .q     (sh_q)
  );

  assign sh_load  = (state_q == ST_IDLE) && START;
  assign sh_shift = (state_q == ST_LOAD) || (state_q == ST_UNLOAD);
  assign sh_sin   = (state_q == ST_UNLOAD) && SO;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (cnt_q == LAST) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CAPTURE: begin
        state_d = ST_UNLOAD;
        cnt_d   = '0;
      end
      ST_UNLOAD: begin
        if (cnt_q == LAST) begin
          state_d = ST_FINISH;
          cnt_d   = '0;
          // Last sample is taken straight from SO on this edge, so RESP
          // is complete in the FINISH cycle when DONE rises.
          resp_d  = {sh_q[CHAIN_LEN-2:0], SO};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they
    // line up with state_q and never see an input combinationally.
    se_d   = (state_d == ST_LOAD) || (state_d == ST_UNLOAD);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FINISH);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      resp_q  <= '0;
      se_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      se_q    <= se_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // SI is the shift register MSB gated by the registered LOAD state; both
  // are flops, so there is still no path from any input.
  assign SI   = (state_q == ST_LOAD) && sh_q[CHAIN_LEN-1];
  assign SE   = se_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign RESP = resp_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: an 8-flop chain whose functional D is ~Q, so
// the captured response is always the bitwise inverse of the loaded pattern.
module tb_scan_chain_ctrl;

  logic       CK = 1'b0;
  logic       RST, START, SO, SE, SI, BUSY, DONE;
  logic [7:0] PATTERN, RESP;
  logic [7:0] chain = '0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;

  logic       si_exp[$];
  logic [7:0] resp_exp[$];
  logic [7:0] b2b [3] = '{8'h3C, 8'hC3, 8'h81};

  scan_chain_ctrl #(.CHAIN_LEN(8)) dut (
    .CK(CK), .RST(RST), .START(START), .PATTERN(PATTERN), .SO(SO),
    .SE(SE), .SI(SI), .RESP(RESP), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CK = ~CK;

  always @(posedge CK) chain <= SE ? {chain[6:0], SI} : ~chain;
  assign SO = chain[7];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] p);
    for (int i = 7; i >= 0; i--) si_exp.push_back(p[i]);
    resp_exp.push_back(~p);
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CK);
      if (DONE === 1'b1) got = 1'b1;
    end
    chk1("done_seen", got, 1'b1);
  endtask

  task automatic run_one(input logic [7:0] p);
    PATTERN = p;
    START   = 1'b1;
    push_exp(p);
    tick();
    START   = 1'b0;
    wait_done();
  endtask

  // Monitor: cycle k of a sequence is the k-th cycle with BUSY high.
  // 1..8 LOAD, 9 CAPTURE, 10..17 UNLOAD, 18 FINISH.
  always @(negedge CK) begin
    if (RST !== 1'b0) begin
      cyc = 0;
    end else begin
      if (BUSY === 1'b1) cyc++;
      else               cyc = 0;
      if (cyc >= 1 && cyc <= 8) begin
        chk1("load_se", SE, 1'b1);
        checks++;
        assert (si_exp.size() > 0) else begin
          errors++;
          $error("FAIL si_queue: observed size 0 expected nonzero");
        end
        if (si_exp.size() > 0) chk1("load_si", SI, si_exp.pop_front());
      end
      if (cyc == 9) begin
        chk1("capture_se", SE, 1'b0);
        chk1("capture_si", SI, 1'b0);
      end
      if (cyc >= 10 && cyc <= 17) begin
        chk1("unload_se", SE, 1'b1);
        chk1("unload_si", SI, 1'b0);
      end
      if (cyc == 18) begin
        chk1("finish_done", DONE, 1'b1);
        chk1("finish_se", SE, 1'b0);
        checks++;
        assert (resp_exp.size() > 0) else begin
          errors++;
          $error("FAIL resp_queue: observed size 0 expected nonzero");
        end
        if (resp_exp.size() > 0) chk8("resp_at_done", RESP, resp_exp.pop_front());
      end
      if (DONE === 1'b1) begin
        done_cnt++;
        chk8("done_cycle", 8'(cyc), 8'd18);
      end
    end
  end

  initial begin
    int d0;
    RST = 1'b1; START = 1'b0; PATTERN = '0;

    // Scenario 1: reset then idle
    tick(); tick();
    RST = 1'b0;
    tick();
    chk1("rst_se", SE, 1'b0);
    chk1("rst_si", SI, 1'b0);
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_done", DONE, 1'b0);
    chk8("rst_resp", RESP, 8'h00);

    // Scenario 2: single sequence with A5
    run_one(8'hA5);
    chk8("s2_resp", RESP, 8'h5A);
    tick();
    chk8("s2_resp_hold", RESP, 8'h5A);

    // Scenario 3: START held, back-to-back with one IDLE cycle between
    START = 1'b1;
    for (int k = 0; k < 3; k++) begin
      PATTERN = b2b[k];
      push_exp(b2b[k]);
      tick();
      chk1("b2b_busy", BUSY, 1'b1);
      if (k == 2) START = 1'b0;
      wait_done();
      chk8("b2b_resp", RESP, ~b2b[k]);
      tick();
      chk1("b2b_gap_idle", BUSY, 1'b0);
    end

    // Scenario 4: reset in the 4th UNLOAD cycle (sequence cycle 13)
    PATTERN = 8'h96;
    START   = 1'b1;
    push_exp(8'h96);
    tick();
    START   = 1'b0;
    repeat (12) tick();
    chk1("s4_unload_se", SE, 1'b1);
    d0  = done_cnt;
    RST = 1'b1;
    tick();
    chk1("s4_se", SE, 1'b0);
    chk1("s4_si", SI, 1'b0);
    chk1("s4_busy", BUSY, 1'b0);
    chk1("s4_done", DONE, 1'b0);
    chk8("s4_resp", RESP, 8'h00);
    RST = 1'b0;
    si_exp.delete();
    resp_exp.delete();
    repeat (25) tick();
    chk8("s4_no_done", 8'(done_cnt), 8'(d0));

    // Scenario 5: START with new PATTERN during LOAD is ignored
    d0 = done_cnt;
    PATTERN = 8'h5C;
    START   = 1'b1;
    push_exp(8'h5C);
    tick();
    START = 1'b0;
    tick(); tick();
    PATTERN = 8'hFF;
    START   = 1'b1;
    tick();
    START   = 1'b0;
    PATTERN = 8'h00;
    wait_done();
    chk8("s5_resp", RESP, 8'hA3);
    repeat (25) tick();
    chk8("s5_one_done", 8'(done_cnt), 8'(d0 + 1));
    chk1("s5_idle", BUSY, 1'b0);

    // Scenario 6: all-zero and all-one patterns
    run_one(8'h00);
    chk8("s6_resp_ff", RESP, 8'hFF);
    tick();
    run_one(8'hFF);
    chk8("s6_resp_00", RESP, 8'h00);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
